cmp_sub_pipe: RTL
=================

Name: cmp_sub_pipe

Overview:
Multi-channel, pipelined successor to the single-channel strategy comparator. It compares NUM_CH pairs (value_hi, value_lo) per beat under a per-channel mode (GT/GE/LT/EQ). Each compare is split at SUB_EARLY_WIDTH into early (LSB) and late (MSB) partial compares to meet timing. It also reports an any-hit flag and the lowest hitting channel index to the strategy decision logic.

Parameters:
NUM_CH, 4, number of compare channels (1..16)
SUB_DATA_WIDTH, 32, width of each compared value
SUB_EARLY_WIDTH, 24, LSB split point; legal range 1..SUB_DATA_WIDTH-1, elaboration error otherwise
SUB_PIPE, 0, 0: latency 1; 1: extra output register stage, latency 2
IDX_W, $clog2(NUM_CH) min 1, width of first_idx (localparam)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
value_hi  in  NUM_CH*SUB_DATA_WIDTH  packed high operands; channel c at [c*W +: W]
value_lo  in  NUM_CH*SUB_DATA_WIDTH  packed low operands, same packing
mode  in  NUM_CH*2  per-channel cmp_mode_t, channel c at [c*2 +: 2]
ch_en  in  NUM_CH  channel enable mask
out_valid  out  1  result beat valid
cond_true  out  NUM_CH  per-channel compare result (masked by ch_en)
any_true  out  1  OR of cond_true
first_idx  out  IDX_W  lowest c with cond_true[c]=1; 0 when any_true=0

Behaviour:
- Single clock (clk); reset synchronous, active-high.
- Reset: out_valid=0, cond_true=0, any_true=0, first_idx=0; all pipeline valid bits cleared. Beats in flight at reset are dropped, never emitted. A beat presented in the reset cycle is dropped.
- No backpressure. One beat accepted per cycle when in_valid=1. Back-to-back beats produce back-to-back results in order.
- Operands are unsigned.
- Stage 1 registers, per channel:
  - lo_gt and lo_eq on bits [SUB_EARLY_WIDTH-1:0].
  - hi_gt and hi_eq on bits [SUB_DATA_WIDTH-1:SUB_EARLY_WIDTH].
  - mode and ch_en.
  - valid.
- Combine: gt = hi_gt | (hi_eq & lo_gt); eq = hi_eq & lo_eq.
- Mode results: GT -> gt; GE -> gt|eq; LT -> ~gt & ~eq; EQ -> eq.
- cond_true[c] = mode result AND ch_en[c].
- SUB_PIPE=0: combine, any_true and first_idx are combinational from stage-1 registers. Latency 1: result appears the cycle after in_valid.
- SUB_PIPE=1: combined cond_true, any_true, first_idx and valid are registered. Latency 2.
- When out_valid=0, outputs hold their last values. Consumers qualify with out_valid. Exception: after reset all outputs read 0.
- Boundary cases:
  - hi==lo: GT=0, GE=1, LT=0, EQ=1.
  - All-ones vs zero handled without overflow (no subtraction carry used).
  - Values differing only in bit SUB_EARLY_WIDTH-1, or only in bit SUB_EARLY_WIDTH, must resolve correctly across the split.
  - ch_en=0 forces cond_true[c]=0 in every mode.
  - NUM_CH=1: first_idx is 1 bit, always 0.

Decomposition:
- tts_pkg gets typedef enum logic[1:0] cmp_mode_t {CMP_GT=0, CMP_GE=1, CMP_LT=2, CMP_EQ=3}.
- Sub-module cmp_split_lane (one per channel, generate loop): stage-1 split compare registers plus combine/mode logic. Parameters SUB_DATA_WIDTH and SUB_EARLY_WIDTH.
- Priority encoder for first_idx stays inline in the top level.

Test Plan:
1. Reset/latency: SUB_PIPE=0, assert reset 3 cycles, then one beat: ch0 hi=5, lo=3, GT, ch_en=0001. Response: out_valid one cycle later; cond_true=0001, any_true=1, first_idx=0. Repeat with SUB_PIPE=1: result two cycles later.
2. Modes at equality: all channels hi=lo=0x00FF_FFFF, modes {GT,GE,LT,EQ}, ch_en=1111. Response: cond_true=1010 (ch1 GE, ch3 EQ), first_idx=1.
3. Split boundary: hi=0x0100_0000, lo=0x00FF_FFFF, GT. Response: 1. Swap operands: 0. hi=0x0080_0000 vs lo=0x007F_FFFF, GT: 1. Extremes: hi=0xFFFF_FFFF, lo=0, LT: 0.
4. Mask and priority: all channels GT true, ch_en=1100. Response: cond_true=1100, first_idx=2. ch_en=0000: any_true=0, first_idx=0.
5. Throughput: 8 back-to-back beats with distinct values, then 2 idle cycles. Response: 8 consecutive out_valid results matching a reference model, in order, then out_valid=0.
6. Reset mid-flight: SUB_PIPE=1, two beats in flight, assert reset for 1 cycle. Response: out_valid stays 0 and no stale result ever appears. The next post-reset beat returns correctly with latency 2.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types for the strategy comparator: compare mode encoding and mode evaluation.
package tts_pkg;

  typedef enum logic [1:0] {
    CMP_GT = 2'd0,
    CMP_GE = 2'd1,
    CMP_LT = 2'd2,
    CMP_EQ = 2'd3
  } cmp_mode_t;

  // Maps combined greater/equal flags onto the requested relation.
  function automatic logic mode_result(input cmp_mode_t m, input logic gt, input logic eq);
    logic r;
    r = 1'b0;
    case (m)
      CMP_GT:  r = gt;
      CMP_GE:  r = gt | eq;
      CMP_LT:  r = ~gt & ~eq;
      CMP_EQ:  r = eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_split_lane.sv
// One compare channel: registered early (LSB) / late (MSB) partial compares,
// then combinational combine and mode selection from those registers.
module cmp_split_lane
  import tts_pkg::*;
#(
  parameter int unsigned SUB_DATA_WIDTH  = 32,
  parameter int unsigned SUB_EARLY_WIDTH = 24
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_i,
  input  logic [SUB_DATA_WIDTH-1:0] hi_i,
  input  logic [SUB_DATA_WIDTH-1:0] lo_i,
  input  cmp_mode_t                 mode_i,
  input  logic                      en_i,
  output logic                      cond_c
);

  generate
    if (SUB_EARLY_WIDTH < 1 || SUB_EARLY_WIDTH > SUB_DATA_WIDTH - 1) begin : g_bad_split
      $error("cmp_split_lane: SUB_EARLY_WIDTH must be in 1..SUB_DATA_WIDTH-1");
    end
  endgenerate

  logic      lo_gt_q, lo_eq_q, hi_gt_q, hi_eq_q;
  logic      lo_gt_d, lo_eq_d, hi_gt_d, hi_eq_d;
  cmp_mode_t mode_q;
  logic      en_q;
  logic      gt_c, eq_c;

  // Magnitude compares only; no subtraction, so all-ones vs zero cannot overflow.
  always_comb begin
    lo_gt_d = hi_i[SUB_EARLY_WIDTH-1:0] >  lo_i[SUB_EARLY_WIDTH-1:0];
    lo_eq_d = hi_i[SUB_EARLY_WIDTH-1:0] == lo_i[SUB_EARLY_WIDTH-1:0];
    hi_gt_d = hi_i[SUB_DATA_WIDTH-1:SUB_EARLY_WIDTH] >  lo_i[SUB_DATA_WIDTH-1:SUB_EARLY_WIDTH];
    hi_eq_d = hi_i[SUB_DATA_WIDTH-1:SUB_EARLY_WIDTH] == lo_i[SUB_DATA_WIDTH-1:SUB_EARLY_WIDTH];
  end

  // Registers only load on accepted beats so results hold while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lo_gt_q <= 1'b0;
      lo_eq_q <= 1'b0;
      hi_gt_q <= 1'b0;
      hi_eq_q <= 1'b0;
      mode_q  <= CMP_GT;
      en_q    <= 1'b0;
    end else if (load_i) begin
      lo_gt_q <= lo_gt_d;
      lo_eq_q <= lo_eq_d;
      hi_gt_q <= hi_gt_d;
      hi_eq_q <= hi_eq_d;
      mode_q  <= mode_i;
      en_q    <= en_i;
    end
  end

  always_comb begin
    gt_c   = hi_gt_q | (hi_eq_q & lo_gt_q);
    eq_c   = hi_eq_q & lo_eq_q;
    cond_c = mode_result(mode_q, gt_c, eq_c) & en_q;
  end

endmodule

// File: rtl/cmp_sub_pipe.sv
// Multi-channel split comparator with any-hit flag and lowest-hit channel index;
// latency 1 (SUB_PIPE=0) or 2 (SUB_PIPE=1).
module cmp_sub_pipe
  import tts_pkg::*;
#(
  parameter  int unsigned NUM_CH          = 4,
  parameter  int unsigned SUB_DATA_WIDTH  = 32,
  parameter  int unsigned SUB_EARLY_WIDTH = 24,
  parameter  int unsigned SUB_PIPE        = 0,
  localparam int unsigned IDX_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic [NUM_CH*SUB_DATA_WIDTH-1:0] value_hi,
  input  logic [NUM_CH*SUB_DATA_WIDTH-1:0] value_lo,
  input  logic [NUM_CH*2-1:0]              mode,
  input  logic [NUM_CH-1:0]                ch_en,
  output logic                             out_valid,
  output logic [NUM_CH-1:0]                cond_true,
  output logic                             any_true,
  output logic [IDX_W-1:0]                 first_idx
);

  logic              s1_valid_q;
  logic [NUM_CH-1:0] cond_c;
  logic              any_c;
  logic [IDX_W-1:0]  first_idx_c;

  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= in_valid;
  end

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_lane
    cmp_split_lane #(
      .SUB_DATA_WIDTH (SUB_DATA_WIDTH),
      .SUB_EARLY_WIDTH(SUB_EARLY_WIDTH)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .load_i(in_valid),
      .hi_i  (value_hi[c*SUB_DATA_WIDTH +: SUB_DATA_WIDTH]),
      .lo_i  (value_lo[c*SUB_DATA_WIDTH +: SUB_DATA_WIDTH]),
      .mode_i(cmp_mode_t'(mode[c*2 +: 2])),
      .en_i  (ch_en[c]),
      .cond_c(cond_c[c])
    );
  end

  // Priority encoder: descending scan leaves the lowest hitting channel.
  always_comb begin
    any_c       = |cond_c;
    first_idx_c = '0;
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (cond_c[c]) first_idx_c = IDX_W'(c);
    end
  end

  generate
    if (SUB_PIPE != 0) begin : g_pipe
      logic              out_valid_q;
      logic [NUM_CH-1:0] cond_q;
      logic              any_q;
      logic [IDX_W-1:0]  first_idx_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          out_valid_q <= 1'b0;
          cond_q      <= '0;
          any_q       <= 1'b0;
          first_idx_q <= '0;
        end else begin
          out_valid_q <= s1_valid_q;
          if (s1_valid_q) begin
            cond_q      <= cond_c;
            any_q       <= any_c;
            first_idx_q <= first_idx_c;
          end
        end
      end

      assign out_valid = out_valid_q;
      assign cond_true = cond_q;
      assign any_true  = any_q;
      assign first_idx = first_idx_q;
    end else begin : g_direct
      assign out_valid = s1_valid_q;
      assign cond_true = cond_c;
      assign any_true  = any_c;
      assign first_idx = first_idx_c;
    end
  endgenerate

endmodule
